// File: rtl/vector_load_unit.sv
// Vector load stage: gathers LANES strided words from data memory, one request
// at a time, and writes them as a single packed vector into the register bank.
module vector_load_unit #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LANES  = 4,
    parameter int unsigned LANE_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [ADDR_W-1:0]        stride,
    input  logic [3:0]               dst_reg,
    output logic                     busy,
    output logic                     done,
    output logic                     mem_re,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [LANE_W-1:0]        mem_rdata,
    input  logic                     mem_valid,
    output logic                     we3,
    output logic [3:0]               wa3,
    output logic [LANES*LANE_W-1:0]  wd3
);

    localparam int unsigned LANE_CW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned DATA_W  = LANES * LANE_W;
    localparam logic [LANE_CW-1:0] LAST_LANE = LANE_CW'(LANES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_WRITE
    } state_e;

    state_e                       state_q, state_d;
    logic [LANE_CW-1:0]           lane_q, lane_d;
    logic [ADDR_W-1:0]            base_q, base_d;
    logic [ADDR_W-1:0]            stride_q, stride_d;
    logic [3:0]                   dst_q, dst_d;
    logic [LANES-1:0][LANE_W-1:0] data_q, data_d;

    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic                         mem_re_q, mem_re_d;
    logic [ADDR_W-1:0]            mem_addr_q, mem_addr_d;
    logic                         we3_q, we3_d;
    logic [3:0]                   wa3_q, wa3_d;
    logic [DATA_W-1:0]            wd3_q, wd3_d;

    // Next-state, datapath and next-output logic; outputs are decoded from the
    // next state so every port comes straight from a flop.
    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        base_d     = base_q;
        stride_d   = stride_q;
        dst_d      = dst_q;
        data_d     = data_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        mem_re_d   = 1'b0;
        mem_addr_d = '0;
        we3_d      = 1'b0;
        wa3_d      = '0;
        wd3_d      = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d   = base_addr;
                    stride_d = stride;
                    dst_d    = dst_reg;
                    lane_d   = '0;
                    data_d   = '0;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_valid) begin
                    data_d[lane_q] = mem_rdata;
                    if (lane_q == LAST_LANE) begin
                        state_d = S_WRITE;
                    end else begin
                        lane_d  = lane_q + LANE_CW'(1);
                        state_d = S_REQ;
                    end
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d   = (state_d != S_IDLE);
        mem_re_d = (state_d == S_REQ);
        if (mem_re_d) begin
            mem_addr_d = base_d + ADDR_W'(lane_d) * stride_d;
        end
        we3_d  = (state_d == S_WRITE);
        done_d = we3_d;
        if (we3_d) begin
            wa3_d = dst_d;
            wd3_d = data_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            lane_q     <= '0;
            base_q     <= '0;
            stride_q   <= '0;
            dst_q      <= '0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mem_re_q   <= 1'b0;
            mem_addr_q <= '0;
            we3_q      <= 1'b0;
            wa3_q      <= '0;
            wd3_q      <= '0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            base_q     <= base_d;
            stride_q   <= stride_d;
            dst_q      <= dst_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mem_re_q   <= mem_re_d;
            mem_addr_q <= mem_addr_d;
            we3_q      <= we3_d;
            wa3_q      <= wa3_d;
            wd3_q      <= wd3_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign mem_re   = mem_re_q;
    assign mem_addr = mem_addr_q;
    assign we3      = we3_q;
    assign wa3      = wa3_q;
    assign wd3      = wd3_q;

endmodule

// File: tb/tb_vector_load_unit.sv
// Scoreboard bench for vector_load_unit: a variable-latency memory responder,
// an address/write reference model, and a monitor that checks every output cycle.
module tb_vector_load_unit;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LANES  = 4;
    localparam int unsigned LANE_W = 32;
    localparam int unsigned DATA_W = LANES * LANE_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W-1:0] stride = '0;
    logic [3:0]        dst_reg = '0;
    logic              busy, done, mem_re, we3;
    logic [ADDR_W-1:0] mem_addr;
    logic [LANE_W-1:0] mem_rdata;
    logic              mem_valid;
    logic [3:0]        wa3;
    logic [DATA_W-1:0] wd3;

    vector_load_unit #(.ADDR_W(ADDR_W), .LANES(LANES), .LANE_W(LANE_W)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .stride(stride), .dst_reg(dst_reg), .busy(busy), .done(done),
        .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_valid(mem_valid), .we3(we3), .wa3(wa3), .wd3(wd3)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]        dst;
        logic [DATA_W-1:0] data;
        int                cyc;
    } wr_t;

    logic [ADDR_W-1:0] exp_addr[$];
    logic [LANE_W-1:0] mem_words[$];
    wr_t               exp_wr[$];

    int n_cmp = 0;
    int n_fail = 0;
    int writes_seen = 0;
    int n_issued = 0;
    int lat_cfg = 1;
    bit stray_en = 1'b0;
    bit rsp_pending = 1'b0;
    int rsp_cnt = 0;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: expected addresses, returned words and final write for one load.
    task automatic issue(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] strd,
                         input logic [3:0] dst, input int lat, input bit fixed,
                         output int exp_cyc);
        wr_t w;
        logic [LANE_W-1:0] word;
        w.data = '0;
        for (int i = 0; i < LANES; i++) begin
            word = fixed ? 32'h1111_1111 * 32'(i + 1) : $urandom;
            exp_addr.push_back(base + strd * 32'(i));
            mem_words.push_back(word);
            w.data[i*LANE_W +: LANE_W] = word;
        end
        w.dst   = dst;
        w.cyc   = cyc + 1 + LANES * (1 + lat);
        exp_cyc = w.cyc;
        lat_cfg = lat;
        exp_wr.push_back(w);
        n_issued++;
        chk("busy_before_start", 128'(busy), 128'(0));
        start = 1'b1; base_addr = base; stride = strd; dst_reg = dst;
        @(negedge clk);
        start = 1'b0; base_addr = $urandom; stride = $urandom; dst_reg = 4'($urandom);
        chk("busy_after_start", 128'(busy), 128'(1));
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic finish_load(input int exp_cyc);
        wait_until(exp_cyc + 1);
        chk("writes_completed", 128'(writes_seen), 128'(n_issued));
        chk("busy_after_write", 128'(busy), 128'(0));
    endtask

    // Memory responder: answers each request lat_cfg cycles later, plus stray pulses.
    initial begin
        mem_valid = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_valid = 1'b0;
            mem_rdata = '0;
            if (!rst) begin
                rsp_pending = 1'b0;
            end else if (rsp_pending) begin
                if (rsp_cnt == 0) begin
                    rsp_pending = 1'b0;
                    mem_valid   = 1'b1;
                    mem_rdata   = (mem_words.size() > 0) ? mem_words.pop_front() : 32'hDEAD_BEEF;
                end else begin
                    rsp_cnt--;
                end
            end else begin
                if (mem_re) begin
                    rsp_pending = 1'b1;
                    rsp_cnt     = lat_cfg - 1;
                end
                if (stray_en && $urandom_range(0, 3) == 0) begin
                    mem_valid = 1'b1;
                    mem_rdata = $urandom;
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a request or a write.
    initial begin
        wr_t w;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (mem_re) begin
                    if (exp_addr.size() == 0) chk("unexpected_mem_re", 128'(mem_re), 128'(0));
                    else chk("mem_addr", 128'(mem_addr), 128'(exp_addr.pop_front()));
                end else begin
                    chk("mem_addr_idle_zero", 128'(mem_addr), 128'(0));
                end
                chk("done_eq_we3", 128'(done), 128'(we3));
                if (we3) begin
                    writes_seen++;
                    if (exp_wr.size() == 0) begin
                        chk("unexpected_we3", 128'(we3), 128'(0));
                    end else begin
                        w = exp_wr.pop_front();
                        chk("wa3", 128'(wa3), 128'(w.dst));
                        chk("wd3", wd3, w.data);
                        chk("we3_cycle", 128'(cyc), 128'(w.cyc));
                        chk("busy_in_write", 128'(busy), 128'(1));
                    end
                end else begin
                    chk("wa3_idle_zero", 128'(wa3), 128'(0));
                    chk("wd3_idle_zero", wd3, 128'(0));
                end
            end
        end
    end

    initial begin
        int c0, e0, e1, seen;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", 128'({busy, done, mem_re, we3, wa3}), 128'(0));
        chk("reset_addr", 128'(mem_addr), 128'(0));
        chk("reset_wd3", wd3, 128'(0));
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Directed load, ignored start mid-load and in WRITE, back-to-back accept.
        c0 = cyc;
        issue(32'h100, 32'd4, 4'h3, 1, 1'b1, e0);
        chk("first_write_cycle", 128'(e0 - c0), 128'(9));
        wait_until(c0 + 4);
        start = 1'b1; dst_reg = 4'h7;
        @(negedge clk);
        start = 1'b0;
        wait_until(c0 + 9);
        start = 1'b1; dst_reg = 4'h9; base_addr = 32'h5000;
        @(negedge clk);
        chk("writes_after_first", 128'(writes_seen), 128'(1));
        chk("busy_low_cycle10", 128'(busy), 128'(0));
        issue($urandom, $urandom, 4'($urandom), 1, 1'b0, e1);
        finish_load(e1);

        // Address wrap-around and stride-0 broadcast.
        issue(32'hFFFF_FFF8, 32'd4, 4'h1, 1, 1'b0, e0);
        finish_load(e0);
        issue(32'h40, 32'd0, 4'h2, 1, 1'b0, e0);
        finish_load(e0);

        // Slow memory with stray valid pulses outside WAIT.
        stray_en = 1'b1;
        c0 = cyc;
        issue(32'h2000, 32'd16, 4'h5, 3, 1'b0, e0);
        chk("slow_write_cycle", 128'(e0 - c0), 128'(17));
        finish_load(e0);

        // Randomized loads with random latency and idle gaps.
        for (int n = 0; n < 12; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue($urandom, (n % 4 == 0) ? 32'd0 : $urandom, 4'($urandom),
                  int'($urandom_range(1, 4)), 1'b0, e0);
            finish_load(e0);
        end

        // Reset mid-load aborts with no write, then a fresh load.
        stray_en = 1'b0;
        c0 = cyc;
        issue(32'h300, 32'd8, 4'h3, 1, 1'b0, e0);
        wait_until(c0 + 6);
        #1 rst = 1'b0;
        #1;
        chk("abort_ctrl", 128'({busy, done, mem_re, we3, wa3}), 128'(0));
        chk("abort_addr", 128'(mem_addr), 128'(0));
        chk("abort_wd3", wd3, 128'(0));
        repeat (2) @(negedge clk);
        exp_addr.delete();
        mem_words.delete();
        exp_wr.delete();
        n_issued--;
        seen = writes_seen;
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("no_write_after_abort", 128'(writes_seen), 128'(seen));
        issue(32'h400, 32'd4, 4'hF, 2, 1'b0, e0);
        finish_load(e0);

        chk("addr_queue_drained", 128'(exp_addr.size()), 128'(0));
        chk("write_queue_drained", 128'(exp_wr.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
